// File: rtl/pong_ball_ctrl.sv
// Ball position, direction and serve sequencing for a 640x480 pong field.
// All motion is committed on the last pixel of the frame so a visible frame never tears.
module pong_ball_ctrl #(
    parameter int BALL_SIZE     = 8,
    parameter int PADDLE_WIDTH  = 8,
    parameter int PADDLE_HEIGHT = 64,
    parameter int P1_X          = 16,
    parameter int P2_X          = 616,
    parameter int SPEED_DIV     = 1,
    parameter int SERVE_FRAMES  = 60
) (
    input  logic       i_Clk,
    input  logic       i_Reset_n,
    input  logic [9:0] i_H_count,
    input  logic [9:0] i_V_count,
    input  logic       i_Start,
    input  logic [9:0] i_P1_V_pos,
    input  logic [9:0] i_P2_V_pos,
    output logic       o_Draw_Ball,
    output logic [9:0] o_Ball_X,
    output logic [9:0] o_Ball_Y,
    output logic       o_P1_Score,
    output logic       o_P2_Score
);
    localparam logic [9:0]  CX        = 10'd316;
    localparam logic [9:0]  CY        = 10'd236;
    localparam logic [9:0]  X_MAX     = 10'(640 - BALL_SIZE);
    localparam logic [9:0]  Y_MAX     = 10'(480 - BALL_SIZE);
    localparam logic [9:0]  LEFT_HIT  = 10'(P1_X + PADDLE_WIDTH);
    localparam logic [9:0]  RIGHT_HIT = 10'(P2_X - BALL_SIZE);
    localparam logic [10:0] BS11      = 11'(BALL_SIZE);
    localparam logic [10:0] PH11      = 11'(PADDLE_HEIGHT);
    localparam int SW  = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;
    localparam int SVW = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
    localparam logic [SW-1:0]  STEP_LAST  = SW'(SPEED_DIV - 1);
    localparam logic [SVW-1:0] SERVE_LAST = SVW'(SERVE_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, PLAY, SCORED} state_t;

    state_t         state, state_nxt;
    logic [9:0]     x, y, x_nxt, y_nxt;
    logic           dx_neg, dy_neg, dx_neg_nxt, dy_neg_nxt;
    logic [SW-1:0]  step_cnt, step_nxt;
    logic [SVW-1:0] serve_cnt, serve_nxt;
    logic           p1_nxt, p2_nxt, draw_nxt;
    logic           frame_tick, ov1, ov2, hit_paddle, hit_wall;
    logic [10:0]    x11, y11, h11, v11;

    assign x11 = {1'b0, x};
    assign y11 = {1'b0, y};
    assign h11 = {1'b0, i_H_count};
    assign v11 = {1'b0, i_V_count};

    assign frame_tick = (i_H_count == 10'd799) && (i_V_count == 10'd524);
    assign ov1 = (y11 + BS11 > {1'b0, i_P1_V_pos}) && (y11 < {1'b0, i_P1_V_pos} + PH11);
    assign ov2 = (y11 + BS11 > {1'b0, i_P2_V_pos}) && (y11 < {1'b0, i_P2_V_pos} + PH11);
    assign hit_paddle = (dx_neg && x == LEFT_HIT && ov1) || (!dx_neg && x == RIGHT_HIT && ov2);
    assign hit_wall   = (dy_neg && y == 10'd0) || (!dy_neg && y == Y_MAX);
    assign draw_nxt   = (h11 >= x11) && (h11 < x11 + BS11) && (v11 >= y11) && (v11 < y11 + BS11);

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state       <= IDLE;
            x           <= CX;
            y           <= CY;
            dx_neg      <= 1'b0;
            dy_neg      <= 1'b0;
            step_cnt    <= '0;
            serve_cnt   <= '0;
            o_Draw_Ball <= 1'b0;
            o_P1_Score  <= 1'b0;
            o_P2_Score  <= 1'b0;
        end else begin
            state       <= state_nxt;
            x           <= x_nxt;
            y           <= y_nxt;
            dx_neg      <= dx_neg_nxt;
            dy_neg      <= dy_neg_nxt;
            step_cnt    <= step_nxt;
            serve_cnt   <= serve_nxt;
            o_Draw_Ball <= draw_nxt;
            o_P1_Score  <= p1_nxt;
            o_P2_Score  <= p2_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        x_nxt      = x;
        y_nxt      = y;
        dx_neg_nxt = dx_neg;
        dy_neg_nxt = dy_neg;
        step_nxt   = step_cnt;
        serve_nxt  = serve_cnt;
        p1_nxt     = 1'b0;
        p2_nxt     = 1'b0;
        if (frame_tick) begin
            if (state != IDLE && !i_Start) begin
                state_nxt  = IDLE;
                x_nxt      = CX;
                y_nxt      = CY;
                dx_neg_nxt = 1'b0;
                dy_neg_nxt = 1'b0;
                step_nxt   = '0;
                serve_nxt  = '0;
            end else begin
                case (state)
                    IDLE: if (i_Start) begin
                        state_nxt = PLAY;
                        step_nxt  = '0;
                    end
                    PLAY: begin
                        step_nxt = (step_cnt == STEP_LAST) ? '0 : step_cnt + 1'b1;
                        if (step_cnt == STEP_LAST) begin
                            if ((dx_neg && x == 10'd0) || (!dx_neg && x == X_MAX)) begin
                                // Serve direction is loaded now; SCORED never moves the ball.
                                p2_nxt     = dx_neg;
                                p1_nxt     = !dx_neg;
                                state_nxt  = SCORED;
                                serve_nxt  = '0;
                                x_nxt      = CX;
                                y_nxt      = CY;
                                dx_neg_nxt = !dx_neg;
                                dy_neg_nxt = 1'b0;
                            end else begin
                                dx_neg_nxt = dx_neg ^ hit_paddle;
                                dy_neg_nxt = dy_neg ^ hit_wall;
                                x_nxt = dx_neg_nxt ? x - 10'd1 : x + 10'd1;
                                y_nxt = dy_neg_nxt ? y - 10'd1 : y + 10'd1;
                            end
                        end
                    end
                    SCORED: begin
                        if (serve_cnt == SERVE_LAST) begin
                            state_nxt = PLAY;
                            serve_nxt = '0;
                            step_nxt  = '0;
                        end else begin
                            serve_nxt = serve_cnt + 1'b1;
                        end
                    end
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    assign o_Ball_X = x;
    assign o_Ball_Y = y;
endmodule

// File: tb/tb_pong_ball_ctrl.sv
// Directed bench for pong_ball_ctrl: a frame-level ball model is checked every cycle,
// with literal expectations at the key points of the rally.
module tb_pong_ball_ctrl;
    localparam int SPEED_DIV = 1;
    localparam int SERVE_FRAMES = 60;

    logic       i_Clk = 1'b0;
    logic       i_Reset_n = 1'b0;
    logic [9:0] hc = 10'd0, vc = 10'd0;
    logic       start = 1'b0;
    logic [9:0] p1pos = 10'd0, p2pos = 10'd0;
    logic       o_Draw_Ball, o_P1_Score, o_P2_Score;
    logic [9:0] o_Ball_X, o_Ball_Y;

    int n_vec = 0, n_err = 0;
    bit chk_en = 0;

    pong_ball_ctrl #(.BALL_SIZE(8), .PADDLE_WIDTH(8), .PADDLE_HEIGHT(64), .P1_X(16),
                     .P2_X(616), .SPEED_DIV(SPEED_DIV), .SERVE_FRAMES(SERVE_FRAMES)) dut (
        .i_Clk(i_Clk), .i_Reset_n(i_Reset_n), .i_H_count(hc), .i_V_count(vc),
        .i_Start(start), .i_P1_V_pos(p1pos), .i_P2_V_pos(p2pos),
        .o_Draw_Ball(o_Draw_Ball), .o_Ball_X(o_Ball_X), .o_Ball_Y(o_Ball_Y),
        .o_P1_Score(o_P1_Score), .o_P2_Score(o_P2_Score));

    always #5 i_Clk = ~i_Clk;

    // mode: 0 idle, 1 play, 2 scored; vx/vy are +1/-1 velocities
    typedef struct {
        int x; int y; int vx; int vy; int mode; int step; int serve; int serve_vx;
        bit p1; bit p2;
    } mdl_t;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.x = 316; r.y = 236; r.vx = 1; r.vy = 1; r.mode = 0; r.step = 0;
        r.serve = 0; r.serve_vx = 1; r.p1 = 0; r.p2 = 0;
        return r;
    endfunction

    function automatic mdl_t advance(mdl_t s, int h, int v, bit st, int pa, int pb);
        mdl_t n = s;
        bit ov1, ov2;
        n.p1 = 0; n.p2 = 0;
        if (!(h == 799 && v == 524)) return n;
        if (s.mode != 0 && !st) begin
            n = mdl_reset();
            return n;
        end
        if (s.mode == 0) begin
            if (st) begin n.mode = 1; n.step = 0; end
        end else if (s.mode == 1) begin
            n.step = (s.step + 1) % SPEED_DIV;
            if (n.step == 0) begin
                if (s.x == 0 && s.vx < 0) begin
                    n.p2 = 1; n.mode = 2; n.x = 316; n.y = 236; n.serve = 0; n.serve_vx = 1;
                end else if (s.x == 632 && s.vx > 0) begin
                    n.p1 = 1; n.mode = 2; n.x = 316; n.y = 236; n.serve = 0; n.serve_vx = -1;
                end else begin
                    ov1 = (s.y + 8 > pa) && (s.y < pa + 64);
                    ov2 = (s.y + 8 > pb) && (s.y < pb + 64);
                    if ((s.y == 0 && s.vy < 0) || (s.y == 472 && s.vy > 0)) n.vy = -s.vy;
                    if ((s.vx < 0 && s.x == 24 && ov1) || (s.vx > 0 && s.x == 608 && ov2)) n.vx = -s.vx;
                    n.x = s.x + n.vx;
                    n.y = s.y + n.vy;
                end
            end
        end else begin
            n.serve = s.serve + 1;
            if (n.serve == SERVE_FRAMES) begin
                n.mode = 1; n.vx = s.serve_vx; n.vy = 1; n.serve = 0; n.step = 0;
            end
        end
        return n;
    endfunction

    mdl_t m;
    bit   e_draw;

    always @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            m      <= mdl_reset();
            e_draw <= 1'b0;
        end else begin
            m      <= advance(m, int'(hc), int'(vc), start, int'(p1pos), int'(p2pos));
            e_draw <= (int'(hc) >= m.x) && (int'(hc) < m.x + 8) &&
                      (int'(vc) >= m.y) && (int'(vc) < m.y + 8);
        end
    end

    always @(negedge i_Clk) begin
        if (chk_en) begin
            n_vec++;
            if (o_Ball_X !== 10'(m.x) || o_Ball_Y !== 10'(m.y) || o_Draw_Ball !== e_draw ||
                o_P1_Score !== m.p1 || o_P2_Score !== m.p2) begin
                n_err++;
                $display("FAIL model t=%0t: got x=%0d y=%0d draw=%b p1=%b p2=%b, expected x=%0d y=%0d draw=%b p1=%b p2=%b",
                         $time, o_Ball_X, o_Ball_Y, o_Draw_Ball, o_P1_Score, o_P2_Score,
                         m.x, m.y, e_draw, m.p1, m.p2);
            end
        end
    end

    task automatic check(string name, int got, int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic ticks(int n);
        hc = 10'd799; vc = 10'd524;
        repeat (n) cyc();
    endtask

    // Tick every cycle until a score pulse appears; which = 1 for P1, 2 for P2, 0 for either.
    task automatic wait_score(string name, int which, int bound);
        bit seen = 0;
        hc = 10'd799; vc = 10'd524;
        for (int i = 0; i < bound && !seen; i++) begin
            cyc();
            if ((which != 2 && o_P1_Score) || (which != 1 && o_P2_Score)) seen = 1;
        end
        check(name, int'(seen), 1);
    endtask

    initial begin
        int cnt;
        bit seen;
        #12;
        chk_en = 1;
        check("reset_x", o_Ball_X, 316);
        check("reset_y", o_Ball_Y, 236);
        check("reset_draw", o_Draw_Ball, 0);
        check("reset_scores", {o_P1_Score, o_P2_Score}, 0);
        @(negedge i_Clk); i_Reset_n = 1'b1;

        // The IDLE->PLAY tick only changes state; the three ticks after it each move the ball.
        start = 1'b1; p1pos = 10'd200; p2pos = 10'd380;
        ticks(1);
        check("enter_play_x", o_Ball_X, 316);
        ticks(3);
        check("play3_x", o_Ball_X, 319);
        check("play3_y", o_Ball_Y, 239);
        ticks(233);
        check("at_floor_y", o_Ball_Y, 472);
        check("at_floor_x", o_Ball_X, 552);
        ticks(1);
        check("floor_bounce_y", o_Ball_Y, 471);
        check("floor_bounce_x", o_Ball_X, 553);

        // Right paddle at 380 returns the ball at (608,416); left paddle at 200 misses at y=168.
        wait_score("p2_score_seen", 2, 3000);
        check("p2_score_centre_x", o_Ball_X, 316);
        check("p2_score_centre_y", o_Ball_Y, 236);
        ticks(1);
        check("p2_pulse_one_cycle", o_P2_Score, 0);
        ticks(58);
        check("serve_hold_x", o_Ball_X, 316);
        ticks(1);
        check("serve_enter_play_x", o_Ball_X, 316);
        ticks(1);
        check("serve_dx_pos_x", o_Ball_X, 317);
        check("serve_dy_pos_y", o_Ball_Y, 237);

        // Right side open: P1 scores; serve then heads left into paddle at 400 (ball y=416).
        p1pos = 10'd400; p2pos = 10'd0;
        wait_score("p1_score_seen", 1, 3000);
        ticks(60);
        hc = 10'd799; vc = 10'd524;
        seen = 0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            cyc();
            if (o_Ball_X == 10'd24) seen = 1;
        end
        check("reach_left_paddle", int'(seen), 1);
        ticks(1);
        check("left_paddle_bounce_x", o_Ball_X, 25);
        check("left_paddle_bounce_y", o_Ball_Y, 415);

        wait_score("any_score_seen", 0, 3000);
        ticks(5);
        start = 1'b0;
        ticks(1);
        check("abort_scored_x", o_Ball_X, 316);
        check("abort_scored_pulse", {o_P1_Score, o_P2_Score}, 0);
        ticks(3);
        check("idle_still_y", o_Ball_Y, 236);

        cnt = 0;
        for (int v = 232; v <= 246; v++)
            for (int h = 310; h <= 330; h++) begin
                hc = 10'(h); vc = 10'(v);
                cyc();
                if (o_Draw_Ball) cnt++;
            end
        check("draw_pixel_count", cnt, 64);
        hc = 10'd0; vc = 10'd0;
        cyc();

        start = 1'b1;
        ticks(2);
        check("restart_x", o_Ball_X, 317);
        hc = 10'd317; vc = 10'd237;
        cyc();
        check("draw_before_reset", o_Draw_Ball, 1);
        #3 i_Reset_n = 1'b0;
        #1;
        check("async_reset_draw", o_Draw_Ball, 0);
        check("async_reset_x", o_Ball_X, 316);
        check("async_reset_y", o_Ball_Y, 236);
        check("async_reset_scores", {o_P1_Score, o_P2_Score}, 0);
        cyc();
        @(negedge i_Clk); i_Reset_n = 1'b1;
        hc = 10'd100; vc = 10'd100;
        repeat (3) cyc();
        ticks(1);
        check("post_reset_enter_x", o_Ball_X, 316);
        ticks(1);
        check("post_reset_move_x", o_Ball_X, 317);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
